cnn_accel_quad_shell: RTL and testbench

Interface and control shell of one CNN layer-accelerator quad. It loads the 512-word convolution sequence memory over a config stream and runs the job handshake with the host fetch engine. Per input row, it streams pixel words into a row FIFO and replays them on the result stream. It sits between the host DMA/job scheduler and the AWE compute engines; the compute engines are outside this block's scope.

---
 rtl/cnn_accel_quad_shell.sv | 169 ++++++++++++++++
 tb/tb_cnn_accel_quad_shell.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_accel_quad_shell.sv
// rtl/cnn_accel_quad_shell.sv - CNN quad shell: sequence memory load, job handshake, row FIFO replay
// Sequence memory and row FIFO storage carry no reset; only their pointers do.
module cnn_accel_quad_shell #(
  parameter int C_PIXEL_WIDTH    = 16,
  parameter int C_NUM_AWE        = 4,
  parameter int C_NUM_CE_PER_AWE = 2,
  parameter int C_BRAM_DEPTH     = 512,
  localparam int W  = C_PIXEL_WIDTH * C_NUM_AWE * C_NUM_CE_PER_AWE,
  localparam int AW = $clog2(C_BRAM_DEPTH)
) (
  input  logic                 clk_if,
  input  logic                 rst,
  input  logic                 job_start,
  output logic                 job_accept,
  input  logic [31:0]          job_parameters,
  output logic                 job_fetch_request,
  input  logic                 job_fetch_ack,
  input  logic                 job_fetch_complete,
  output logic                 job_complete,
  input  logic                 job_complete_ack,
  input  logic [C_NUM_AWE-1:0] config_valid,
  output logic [C_NUM_AWE-1:0] config_accept,
  input  logic [W-1:0]         config_data,
  input  logic                 pixel_valid,
  output logic                 pixel_ready,
  input  logic [W-1:0]         pixel_data,
  output logic                 result_valid,
  input  logic                 result_accept,
  output logic [W-1:0]         result_data,
  input  logic [AW-1:0]        seq_rd_addr,
  output logic [W-1:0]         seq_rd_data
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_FETCH_REQ  = 3'd1;
  localparam logic [2:0] ST_STREAM     = 3'd2;
  localparam logic [2:0] ST_WAIT_DRAIN = 3'd3;
  localparam logic [2:0] ST_COMPLETE   = 3'd4;

  logic [2:0]    state;
  logic [9:0]    rows_m1;
  logic [9:0]    cols_m1;
  logic [9:0]    row_cnt;
  logic [10:0]   col_cnt;
  logic [AW-1:0] wr_ptr;

  logic [W-1:0]  seq_mem  [C_BRAM_DEPTH];
  logic [W-1:0]  fifo_mem [C_BRAM_DEPTH];
  logic [AW-1:0] fifo_wr;
  logic [AW-1:0] fifo_rd;
  logic [AW:0]   fifo_cnt;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic cfg_wr;
  logic unused_params;

  assign unused_params = ^job_parameters[31:20];

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (AW+1)'(C_BRAM_DEPTH));

  // col_cnt is one bit wider than cols_m1 so a full 1024-pixel row can be counted past
  assign config_accept = (state == ST_IDLE) ? config_valid : '0;
  assign pixel_ready   = (state == ST_STREAM) && (col_cnt <= {1'b0, cols_m1}) && !fifo_full;
  assign result_valid  = !fifo_empty;
  assign result_data   = fifo_empty ? '0 : fifo_mem[fifo_rd];

  assign push   = pixel_valid && pixel_ready;
  assign pop    = result_valid && result_accept;
  assign cfg_wr = config_accept[0];

  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      job_accept        <= 1'b0;
      job_fetch_request <= 1'b0;
      job_complete      <= 1'b0;
      rows_m1           <= '0;
      cols_m1           <= '0;
      row_cnt           <= '0;
      col_cnt           <= '0;
    end else begin
      job_accept <= 1'b0;
      if (push)
        col_cnt <= col_cnt + 11'd1;
      case (state)
        ST_IDLE: begin
          if (job_start) begin
            job_accept <= 1'b1;
            rows_m1    <= job_parameters[9:0];
            cols_m1    <= job_parameters[19:10];
            row_cnt    <= '0;
            col_cnt    <= '0;
            state      <= ST_FETCH_REQ;
          end
        end
        ST_FETCH_REQ: begin
          // request rises a cycle after entry; an ack is honoured only while it is up
          if (job_fetch_request && job_fetch_ack) begin
            job_fetch_request <= 1'b0;
            col_cnt           <= '0;
            state             <= ST_STREAM;
          end else begin
            job_fetch_request <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (job_fetch_complete) begin
            row_cnt <= row_cnt + 10'd1;
            state   <= (row_cnt == rows_m1) ? ST_WAIT_DRAIN : ST_FETCH_REQ;
          end
        end
        ST_WAIT_DRAIN: begin
          if (fifo_empty) begin
            job_complete <= 1'b1;
            state        <= ST_COMPLETE;
          end
        end
        ST_COMPLETE: begin
          if (job_complete_ack) begin
            job_complete <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_if or posedge rst) begin
    if (rst)
      wr_ptr <= '0;
    else if (cfg_wr)
      wr_ptr <= wr_ptr + AW'(1);
  end

  always_ff @(posedge clk_if) begin
    if (cfg_wr)
      seq_mem[wr_ptr] <= config_data;
    seq_rd_data <= seq_mem[seq_rd_addr];
  end

  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      fifo_wr  <= '0;
      fifo_rd  <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)
        fifo_wr <= fifo_wr + AW'(1);
      if (pop)
        fifo_rd <= fifo_rd + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_if) begin
    if (push)
      fifo_mem[fifo_wr] <= pixel_data;
  end

endmodule

// File: tb/tb_cnn_accel_quad_shell.sv
// tb/tb_cnn_accel_quad_shell.sv - directed bench for cnn_accel_quad_shell
// Inputs change 1 time unit after the rising edge; results are scored on the falling edge.
module tb_cnn_accel_quad_shell;

  logic         clk_if = 1'b0;
  logic         rst;
  logic         job_start;
  logic         job_accept;
  logic [31:0]  job_parameters;
  logic         job_fetch_request;
  logic         job_fetch_ack;
  logic         job_fetch_complete;
  logic         job_complete;
  logic         job_complete_ack;
  logic [3:0]   config_valid;
  logic [3:0]   config_accept;
  logic [127:0] config_data;
  logic         pixel_valid;
  logic         pixel_ready;
  logic [127:0] pixel_data;
  logic         result_valid;
  logic         result_accept;
  logic [127:0] result_data;
  logic [8:0]   seq_rd_addr;
  logic [127:0] seq_rd_data;

  int total = 0;
  int bad = 0;
  int pop_cnt = 0;
  int fetch_cnt = 0;
  logic [127:0] exp_q[$];

  cnn_accel_quad_shell dut (
    .clk_if(clk_if), .rst(rst),
    .job_start(job_start), .job_accept(job_accept), .job_parameters(job_parameters),
    .job_fetch_request(job_fetch_request), .job_fetch_ack(job_fetch_ack),
    .job_fetch_complete(job_fetch_complete), .job_complete(job_complete),
    .job_complete_ack(job_complete_ack),
    .config_valid(config_valid), .config_accept(config_accept), .config_data(config_data),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_data(pixel_data),
    .result_valid(result_valid), .result_accept(result_accept), .result_data(result_data),
    .seq_rd_addr(seq_rd_addr), .seq_rd_data(seq_rd_data)
  );

  always #5 clk_if = ~clk_if;

  function automatic logic [127:0] cfg(input int i);
    return {32'(i), ~32'(i), 32'h5EC0_0000, 32'(i * 3)};
  endfunction

  function automatic logic [127:0] pix(input int j, input int r, input int c);
    return {32'(j), 32'(r), 32'(c), 32'hDEAD_0000 ^ 32'(j * 7 + c)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_if) begin
    if (!rst && result_valid && result_accept) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL result_extra: observed=%h expected=none", result_data);
      end else begin
        check("result_data", result_data, exp_q.pop_front());
      end
      pop_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk_if);
    #1;
  endtask

  task automatic start_job(input logic [31:0] p);
    job_parameters = p;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    check("accept_pulse", job_accept, 1);
    check("req_not_yet", job_fetch_request, 0);
    tick();
    check("accept_one_cycle", job_accept, 0);
    check("req_rise", job_fetch_request, 1);
  endtask

  task automatic fetch_ack();
    int t = 0;
    while (job_fetch_request !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    check("req_seen", job_fetch_request, 1);
    job_fetch_ack = 1'b1;
    tick();
    job_fetch_ack = 1'b0;
    check("req_drop", job_fetch_request, 0);
    fetch_cnt++;
  endtask

  task automatic push_pix(input int j, input int r, input int c);
    int t = 0;
    pixel_data = pix(j, r, c);
    pixel_valid = 1'b1;
    #1;
    while (pixel_ready !== 1'b1 && t < 40) begin
      tick();
      t++;
    end
    check("pixel_ready_seen", pixel_ready, 1);
    if (pixel_ready === 1'b1) exp_q.push_back(pix(j, r, c));
    tick();
    pixel_valid = 1'b0;
  endtask

  task automatic end_row();
    pixel_valid = 1'b0;
    job_fetch_complete = 1'b1;
    tick();
    job_fetch_complete = 1'b0;
  endtask

  task automatic finish_job();
    int t = 0;
    while (job_complete !== 1'b1 && t < 2000) begin
      tick();
      t++;
    end
    check("complete_seen", job_complete, 1);
    check("drained_at_complete", result_valid, 0);
    tick();
    check("complete_held", job_complete, 1);
    job_complete_ack = 1'b1;
    tick();
    job_complete_ack = 1'b0;
    check("complete_cleared", job_complete, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    job_start = 0; job_parameters = 0; job_fetch_ack = 0; job_fetch_complete = 0;
    job_complete_ack = 0; config_valid = 0; config_data = 0; pixel_valid = 0;
    pixel_data = 0; result_accept = 0; seq_rd_addr = 0;
    repeat (3) tick();
    check("rst_accept", job_accept, 0);
    check("rst_req", job_fetch_request, 0);
    check("rst_complete", job_complete, 0);
    check("rst_cfg_accept", config_accept, 0);
    check("rst_pixel_ready", pixel_ready, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_data", result_data, 0);
    rst = 1'b0;
    tick();

    // config load: 512 lane-0 words
    config_valid = 4'b0001;
    for (int i = 0; i < 512; i++) begin
      config_data = cfg(i);
      #1;
      check("cfg_accept", config_accept, 4'b0001);
      tick();
    end
    config_valid = 0;
    seq_rd_addr = 0;
    tick();
    check("seq_rd_0", seq_rd_data, cfg(0));
    seq_rd_addr = 9'd511;
    tick();
    check("seq_rd_511", seq_rd_data, cfg(511));
    config_valid = 4'b1110;
    config_data = 128'hBAD;
    #1;
    check("cfg_accept_hi_lanes", config_accept, 4'b1110);
    tick();
    config_valid = 4'b0001;
    config_data = cfg(777);
    tick();
    config_valid = 0;
    seq_rd_addr = 0;
    tick();
    check("seq_wrap_overwrite", seq_rd_data, cfg(777));
    seq_rd_addr = 1;
    tick();
    check("seq_hi_lanes_dropped", seq_rd_data, cfg(1));

    // full job 10x10 with overrun on row 3
    result_accept = 1'b1;
    pop_cnt = 0;
    fetch_cnt = 0;
    start_job(32'h0000_2409);
    config_valid = 4'b1111;
    #1;
    check("cfg_accept_busy", config_accept, 0);
    config_valid = 0;
    for (int r = 0; r < 10; r++) begin
      fetch_ack();
      for (int c = 0; c < 10; c++) push_pix(1, r, c);
      if (r == 3) begin
        pixel_data = pix(1, 3, 10);
        pixel_valid = 1'b1;
        #1;
        check("overrun_ready_low", pixel_ready, 0);
        tick();
        check("overrun_ready_still_low", pixel_ready, 0);
        pixel_valid = 1'b0;
      end
      if (r == 5) begin
        job_start = 1'b1;
        tick();
        job_start = 1'b0;
        check("start_ignored_busy", job_accept, 0);
      end
      end_row();
    end
    finish_job();
    check("full_pop_cnt", pop_cnt, 100);
    check("full_fetch_cnt", fetch_cnt, 10);
    check("full_queue_empty", exp_q.size(), 0);

    // backpressure: 1 row of 520, FIFO fills at 512
    result_accept = 1'b0;
    pop_cnt = 0;
    start_job(32'h0008_1C00);
    fetch_ack();
    for (int c = 0; c < 512; c++) push_pix(2, 0, c);
    check("bp_result_valid", result_valid, 1);
    pixel_data = pix(2, 0, 512);
    pixel_valid = 1'b1;
    #1;
    check("bp_full_ready_low", pixel_ready, 0);
    repeat (3) tick();
    check("bp_full_ready_held", pixel_ready, 0);
    check("bp_no_pop", pop_cnt, 0);
    result_accept = 1'b1;
    for (int c = 512; c < 520; c++) push_pix(2, 0, c);
    end_row();
    finish_job();
    check("bp_pop_cnt", pop_cnt, 520);
    check("bp_queue_empty", exp_q.size(), 0);

    // reset mid-job, then a 2x4 job with a short first row
    result_accept = 1'b0;
    start_job(32'h0000_0C01);
    fetch_ack();
    push_pix(3, 0, 0);
    push_pix(3, 0, 1);
    pixel_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst_ready", pixel_ready, 0);
    check("midrst_result_valid", result_valid, 0);
    check("midrst_result_data", result_data, 0);
    check("midrst_req", job_fetch_request, 0);
    check("midrst_accept", job_accept, 0);
    check("midrst_complete", job_complete, 0);
    check("midrst_cfg_accept", config_accept, 0);
    exp_q.delete();
    pixel_valid = 1'b0;
    tick();
    rst = 1'b0;
    config_valid = 4'b0100;
    #1;
    check("midrst_idle", config_accept, 4'b0100);
    config_valid = 0;
    tick();
    result_accept = 1'b1;
    pop_cnt = 0;
    fetch_cnt = 0;
    start_job(32'h0000_0C01);
    fetch_ack();
    push_pix(4, 0, 0);
    push_pix(4, 0, 1);
    end_row();
    fetch_ack();
    for (int c = 0; c < 4; c++) push_pix(4, 1, c);
    end_row();
    finish_job();
    check("post_rst_pop_cnt", pop_cnt, 6);
    check("post_rst_fetch_cnt", fetch_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
